// File: rtl/cl_pcim_result_writer_pkg.sv
// pcim_wr_pkg: shared types and constants for the PCIM result writer
package pcim_wr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int BURST_BYTES = 4096;
  localparam logic [2:0] AXSIZE_64B = 3'b110;
  localparam logic [63:0] WSTRB_ALL = '1;
endpackage

// File: rtl/cl_pcim_result_writer_if.sv
// cl_pcim_result_writer_if: AXI4 write-only PCIM bus (AW, W, B channels)
interface cl_pcim_result_writer_if #(parameter int ID_W = 16);
  logic [ID_W-1:0] awid;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic awvalid;
  logic awready;
  logic [511:0] wdata;
  logic [63:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/cl_pcim_result_writer.sv
// cl_pcim_result_writer: writes the 512-bit result stream to host memory as fixed 4 KiB INCR bursts
module cl_pcim_result_writer
  import pcim_wr_pkg::*;
#(
  parameter int ID_W = 16,
  parameter int BURST_BEATS = 64,
  parameter int MAX_OUT = 4,
  parameter int AWID_VAL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_start,
  input  logic [63:0] cfg_base_addr,
  input  logic [15:0] cfg_num_bursts,
  output logic busy,
  output logic done,
  output logic err,
  output logic [15:0] bursts_done,
  input  logic [511:0] s_tdata,
  input  logic s_tvalid,
  output logic s_tready,
  cl_pcim_result_writer_if.master pcim
);
  localparam int BW = $clog2(BURST_BEATS);
  state_t state, state_n;
  logic [63:0] base, base_n, awaddr, awaddr_n;
  logic [15:0] num, num_n, aw_cnt, aw_n, w_cnt, w_n, b_cnt, b_n;
  logic [BW-1:0] beat_cnt, beat_n;
  logic awvalid, awvalid_n, err_n, done_n;
  logic w_ok, wlast, aw_hs, w_hs, b_hs, aw_hold;
  assign w_ok = (state == RUN) && (w_cnt < aw_cnt);
  assign wlast = beat_cnt == BW'(BURST_BEATS - 1);
  assign aw_hs = awvalid & pcim.awready;
  assign w_hs = s_tvalid & w_ok & pcim.wready;
  assign b_hs = pcim.bvalid & pcim.bready;
  assign aw_hold = awvalid & ~pcim.awready;
  assign pcim.awid = ID_W'(AWID_VAL);
  assign pcim.awaddr = awaddr;
  assign pcim.awlen = 8'(BURST_BEATS - 1);
  assign pcim.awsize = AXSIZE_64B;
  assign pcim.awvalid = awvalid;
  assign pcim.wdata = s_tdata;
  assign pcim.wstrb = WSTRB_ALL;
  assign pcim.wlast = wlast;
  assign pcim.wvalid = s_tvalid & w_ok;
  assign pcim.bready = 1'b1;
  assign s_tready = pcim.wready & w_ok;
  assign busy = state != IDLE;
  assign bursts_done = b_cnt;
  // next-state, counter and AW-issue decisions; awvalid looks at post-edge counts
  always_comb begin
    state_n = state;
    base_n = base;
    num_n = num;
    aw_n = aw_cnt;
    w_n = w_cnt;
    b_n = b_cnt;
    beat_n = beat_cnt;
    err_n = err;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (cfg_start) begin
        base_n = {cfg_base_addr[63:12], 12'h000};
        num_n = cfg_num_bursts;
        aw_n = '0;
        w_n = '0;
        b_n = '0;
        beat_n = '0;
        err_n = 1'b0;
        state_n = cfg_num_bursts == '0 ? IDLE : RUN;
        done_n = cfg_num_bursts == '0;
      end
    end else begin
      aw_n = aw_cnt + 16'(aw_hs);
      w_n = w_cnt + 16'(w_hs & wlast);
      beat_n = w_hs ? (wlast ? '0 : beat_cnt + 1'b1) : beat_cnt;
      b_n = b_cnt + 16'(b_hs);
      err_n = err | (b_hs & |pcim.bresp);
      if (state == RUN && w_n == num) state_n = DRAIN;
      if (state_n == DRAIN && b_n == num) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end
    awvalid_n = aw_hold | ((state_n == RUN) && (aw_n < num_n) && ((aw_n - b_n) < 16'(MAX_OUT)));
    awaddr_n = aw_hold ? awaddr : base_n + 64'(aw_n) * 64'(BURST_BYTES);
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base <= '0;
      num <= '0;
      aw_cnt <= '0;
      w_cnt <= '0;
      b_cnt <= '0;
      beat_cnt <= '0;
      err <= 1'b0;
      done <= 1'b0;
      awvalid <= 1'b0;
      awaddr <= '0;
    end else begin
      state <= state_n;
      base <= base_n;
      num <= num_n;
      aw_cnt <= aw_n;
      w_cnt <= w_n;
      b_cnt <= b_n;
      beat_cnt <= beat_n;
      err <= err_n;
      done <= done_n;
      awvalid <= awvalid_n;
      awaddr <= awaddr_n;
    end
  end
endmodule

// File: tb/tb_cl_pcim_result_writer.sv
// tb_cl_pcim_result_writer: directed scenarios against an AXI slave model and stream source
module tb_cl_pcim_result_writer;
  import pcim_wr_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic cfg_start = 0;
  logic [63:0] cfg_base_addr = '0;
  logic [15:0] cfg_num_bursts = '0;
  logic busy, done, err;
  logic [15:0] bursts_done;
  logic [511:0] s_tdata;
  logic s_tvalid;
  logic s_tready;
  cl_pcim_result_writer_if #(.ID_W(16)) pcim ();
  cl_pcim_result_writer #(.ID_W(16), .BURST_BEATS(64), .MAX_OUT(4), .AWID_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_bursts(cfg_num_bursts), .busy(busy), .done(done), .err(err),
    .bursts_done(bursts_done), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .pcim(pcim)
  );
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int rand_mode = 0, b_limit = 1000, err_idx = -1;
  logic tb_clr = 0;
  int cyc = 0, w_beats = 0, w_bad = 0, aw_bad = 0, wlast_cnt = 0, b_seen = 0;
  int b_cyc = -1, done_cnt = 0, done_cyc = -1, b_issued = 0;
  logic [63:0] aw_q[$];
  logic aw_pend = 0;
  logic [63:0] aw_last = '0;

  function automatic logic [511:0] mk(int i);
    return {8{64'hA5A5_0000_0000_0000 | 64'(i)}};
  endfunction

  // monitor: samples mid-cycle, records handshakes and protocol violations
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tb_clr) begin
      aw_q.delete();
      w_beats = 0; w_bad = 0; aw_bad = 0; wlast_cnt = 0; b_seen = 0;
      b_cyc = -1; done_cnt = 0; done_cyc = -1; aw_pend = 0;
    end else if (rst_n) begin
      if (pcim.wvalid && pcim.wready) begin
        if (pcim.wdata !== mk(w_beats) || pcim.wlast !== (w_beats % 64 == 63) ||
            pcim.wstrb !== {64{1'b1}} || w_beats / 64 >= aw_q.size()) w_bad++;
        if (pcim.wlast) wlast_cnt++;
        w_beats++;
      end
      if (aw_pend && (!pcim.awvalid || pcim.awaddr !== aw_last)) aw_bad++;
      if (pcim.awvalid && pcim.awready) begin
        aw_q.push_back(pcim.awaddr);
        if (pcim.awlen !== 8'd63 || pcim.awsize !== 3'b110 || pcim.awid !== 16'd0) aw_bad++;
      end
      aw_pend = pcim.awvalid && !pcim.awready;
      aw_last = pcim.awaddr;
      if (pcim.bvalid && pcim.bready) begin b_seen++; b_cyc = cyc; end
      if (aw_q.size() - b_seen > 4) aw_bad++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // driver: stream source and AXI slave responses, updated just after each edge
  initial begin
    pcim.awready = 0; pcim.wready = 0; pcim.bvalid = 0; pcim.bresp = 0; pcim.bid = 0;
    s_tvalid = 0; s_tdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || tb_clr) b_issued = 0;
      s_tvalid = rand_mode == 0 || $urandom_range(0, 2) != 0;
      s_tdata = mk(w_beats);
      pcim.awready = rand_mode == 0 || $urandom_range(0, 1) == 1;
      pcim.wready = rand_mode == 0 || $urandom_range(0, 3) != 0;
      if (rst_n && !tb_clr && b_issued < wlast_cnt && b_issued < b_limit &&
          (rand_mode == 0 || $urandom_range(0, 1) == 1)) begin
        pcim.bvalid = 1;
        pcim.bresp = b_issued == err_idx ? 2'b10 : 2'b00;
        pcim.bid = 16'(b_issued);
        b_issued++;
      end else begin
        pcim.bvalid = 0;
        pcim.bresp = 0;
      end
    end
  end

  task automatic pulse_start(input logic [63:0] base, input int num);
    @(posedge clk); #2;
    cfg_base_addr = base; cfg_num_bursts = 16'(num); cfg_start = 1;
    @(posedge clk); #2;
    cfg_start = 0;
  endtask

  task automatic start_job(input logic [63:0] base, input int num);
    @(posedge clk); #2; tb_clr = 1;
    @(posedge clk); #2; tb_clr = 0;
    pulse_start(base, num);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      cycles(1);
      if (done_cnt > 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    cycles(1);
    tests++; if (pcim.awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid got %b want 0", pcim.awvalid); end
    tests++; if (pcim.wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid got %b want 0", pcim.wvalid); end
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready got %b want 0", s_tready); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_status got busy=%b done=%b err=%b want 000", busy, done, err); end
    tests++; if (bursts_done !== 16'd0 || pcim.awaddr !== 64'd0) begin fails++; $display("FAIL reset_counts got bursts_done=%0d awaddr=%h want 0 0", bursts_done, pcim.awaddr); end
    tests++; if (pcim.bready !== 1'b1) begin fails++; $display("FAIL reset_bready got %b want 1", pcim.bready); end
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  task automatic test_single_burst;
    bit ok;
    start_job(64'h1_0000_0000, 1);
    cycles(1);
    tests++; if (pcim.awvalid !== 1'b1 || pcim.awaddr !== 64'h1_0000_0000 || busy !== 1'b1) begin fails++; $display("FAIL single_first_aw got awvalid=%b awaddr=%h busy=%b want 1 100000000 1", pcim.awvalid, pcim.awaddr, busy); end
    wait_done(400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_done_timeout got no done want done"); end
    tests++; if (aw_q.size() != 1 || aw_q[0] !== 64'h1_0000_0000 || aw_bad != 0) begin fails++; $display("FAIL single_aw got n=%0d bad=%0d want n=1 addr 100000000 bad=0", aw_q.size(), aw_bad); end
    tests++; if (w_beats != 64 || wlast_cnt != 1 || w_bad != 0) begin fails++; $display("FAIL single_w got beats=%0d wlast=%0d bad=%0d want 64 1 0", w_beats, wlast_cnt, w_bad); end
    tests++; if (done_cyc != b_cyc + 1) begin fails++; $display("FAIL single_done_timing got done_cyc=%0d b_cyc=%0d want b_cyc+1", done_cyc, b_cyc); end
    tests++; if (bursts_done !== 16'd1 || busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL single_status got bursts_done=%0d busy=%b err=%b want 1 0 0", bursts_done, busy, err); end
  endtask

  task automatic test_b_backpressure;
    bit ok;
    int bad;
    b_limit = 0;
    start_job(64'h2_0000_0000, 8);
    cycles(20);
    bad = 0;
    for (int i = 0; i < aw_q.size(); i++) if (aw_q[i] !== 64'h2_0000_0000 + 64'(i) * 64'h1000) bad++;
    tests++; if (aw_q.size() != 4 || bad != 0 || pcim.awvalid !== 1'b0) begin fails++; $display("FAIL bp_aw_limit got n=%0d badaddr=%0d awvalid=%b want 4 0 0", aw_q.size(), bad, pcim.awvalid); end
    cycles(300);
    tests++; if (aw_q.size() != 4 || wlast_cnt != 4 || bursts_done !== 16'd0) begin fails++; $display("FAIL bp_hold got aw=%0d wlast=%0d bdone=%0d want 4 4 0", aw_q.size(), wlast_cnt, bursts_done); end
    b_limit = 1;
    cycles(10);
    tests++; if (aw_q.size() != 5 || aw_q[4] !== 64'h2_0000_4000 || bursts_done !== 16'd1) begin fails++; $display("FAIL bp_release got aw=%0d bdone=%0d want aw=5 at 200004000 bdone=1", aw_q.size(), bursts_done); end
    b_limit = 1000;
    wait_done(2000, ok);
    tests++; if (!ok || bursts_done !== 16'd8 || w_bad != 0 || aw_bad != 0) begin fails++; $display("FAIL bp_finish got ok=%0d bdone=%0d wbad=%0d awbad=%0d want 1 8 0 0", ok, bursts_done, w_bad, aw_bad); end
  endtask

  task automatic test_random_stall;
    bit ok;
    int bad;
    rand_mode = 1;
    start_job(64'h3_0000_0000, 16);
    wait_done(20000, ok);
    rand_mode = 0;
    bad = 0;
    for (int i = 0; i < aw_q.size(); i++) if (aw_q[i] !== 64'h3_0000_0000 + 64'(i) * 64'h1000) bad++;
    tests++; if (!ok) begin fails++; $display("FAIL rand_done_timeout got no done want done"); end
    tests++; if (aw_q.size() != 16 || bad != 0 || aw_bad != 0) begin fails++; $display("FAIL rand_aw got n=%0d badaddr=%0d awbad=%0d want 16 0 0", aw_q.size(), bad, aw_bad); end
    tests++; if (w_beats != 1024 || wlast_cnt != 16 || w_bad != 0) begin fails++; $display("FAIL rand_w got beats=%0d wlast=%0d bad=%0d want 1024 16 0", w_beats, wlast_cnt, w_bad); end
    tests++; if (bursts_done !== 16'd16 || done_cnt != 1) begin fails++; $display("FAIL rand_status got bdone=%0d done_cnt=%0d want 16 1", bursts_done, done_cnt); end
  endtask

  task automatic test_error;
    bit ok;
    err_idx = 2;
    start_job(64'h4_0000_0000, 5);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      cycles(1);
      if (b_seen >= 3) begin ok = 1; break; end
    end
    tests++; if (!ok || err !== 1'b0) begin fails++; $display("FAIL err_before got ok=%0d err=%b want 1 0", ok, err); end
    cycles(1);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
    wait_done(2000, ok);
    tests++; if (!ok || err !== 1'b1 || bursts_done !== 16'd5 || done_cnt != 1) begin fails++; $display("FAIL err_sticky got ok=%0d err=%b bdone=%0d done_cnt=%0d want 1 1 5 1", ok, err, bursts_done, done_cnt); end
    err_idx = -1;
    start_job(64'h4_1000_0000, 1);
    cycles(1);
    tests++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL err_clear got err=%b busy=%b want 0 1", err, busy); end
    wait_done(400, ok);
    tests++; if (!ok || err !== 1'b0) begin fails++; $display("FAIL err_clean_job got ok=%0d err=%b want 1 0", ok, err); end
  endtask

  task automatic test_edge_config;
    bit ok;
    start_job(64'h5_0000_0000, 0);
    cycles(1);
    tests++; if (done !== 1'b1 || busy !== 1'b0 || pcim.awvalid !== 1'b0) begin fails++; $display("FAIL zero_done got done=%b busy=%b awvalid=%b want 1 0 0", done, busy, pcim.awvalid); end
    cycles(1);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_pulse got done=%b want 0", done); end
    cycles(5);
    tests++; if (aw_q.size() != 0 || done_cnt != 1) begin fails++; $display("FAIL zero_no_aw got aw=%0d done_cnt=%0d want 0 1", aw_q.size(), done_cnt); end
    start_job(64'h6_0000_0000, 2);
    cycles(5);
    pulse_start(64'h7_0000_0000, 1);
    wait_done(1000, ok);
    cycles(3);
    tests++; if (!ok || aw_q.size() != 2 || aw_q[1] !== 64'h6_0000_1000 || bursts_done !== 16'd2 || done_cnt != 1) begin fails++; $display("FAIL busy_start got ok=%0d aw=%0d bdone=%0d done_cnt=%0d want 1 2 2 1", ok, aw_q.size(), bursts_done, done_cnt); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    start_job(64'h8_0000_0000, 4);
    cycles(100);
    tests++; if (busy !== 1'b1 || bursts_done !== 16'd1 || pcim.wvalid !== 1'b1) begin fails++; $display("FAIL mid_pre got busy=%b bdone=%0d wvalid=%b want 1 1 1", busy, bursts_done, pcim.wvalid); end
    rst_n = 0;
    #1;
    tests++; if (pcim.awvalid !== 1'b0 || pcim.wvalid !== 1'b0 || s_tready !== 1'b0) begin fails++; $display("FAIL mid_rst_bus got awvalid=%b wvalid=%b s_tready=%b want 000", pcim.awvalid, pcim.wvalid, s_tready); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bursts_done !== 16'd0 || pcim.awaddr !== 64'd0) begin fails++; $display("FAIL mid_rst_state got busy=%b done=%b err=%b bdone=%0d awaddr=%h want 0 0 0 0 0", busy, done, err, bursts_done, pcim.awaddr); end
    @(posedge clk); #2;
    rst_n = 1;
    start_job(64'h9_0000_0000, 1);
    wait_done(400, ok);
    tests++; if (!ok || bursts_done !== 16'd1 || aw_q.size() != 1 || aw_q[0] !== 64'h9_0000_0000 || w_bad != 0) begin fails++; $display("FAIL mid_recover got ok=%0d bdone=%0d aw=%0d wbad=%0d want 1 1 1 0", ok, bursts_done, aw_q.size(), w_bad); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_b_backpressure();
    test_random_stall();
    test_error();
    test_edge_config();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
